// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the architectural PC, fetches over a req/ack
// handshake and issues each instruction to decode with a valid/ready handshake.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exception,
    input  logic        halt,
    output logic [31:0] epc,
    output logic        adel,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] seq_pc;
    logic [31:0] br_disp;
    logic        accept;
    logic        fetch_done;
    logic        jr_misaligned;
    logic        trap;
    logic        trap_adel;

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);

    assign accept        = instr_valid && instr_ready;
    assign fetch_done    = (state == FETCH) && imem_ack;
    assign seq_pc        = instr_pc + 32'd4;
    assign br_disp       = {{14{br_offset[15]}}, br_offset, 2'b00};
    assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);

    // Redirect selection; only consumed on an accept cycle.
    always_comb begin
        pc_next   = seq_pc;
        trap      = 1'b0;
        trap_adel = 1'b0;
        if (exception) begin
            pc_next = EXC_VECTOR;
            trap    = 1'b1;
        end else if (jr_misaligned) begin
            pc_next   = EXC_VECTOR;
            trap      = 1'b1;
            trap_adel = 1'b1;
        end else if (jr) begin
            pc_next = jr_target;
        end else if (jump) begin
            pc_next = {seq_pc[31:28], jump_index, 2'b00};
        end else if (br_taken) begin
            pc_next = seq_pc + br_disp;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ack) state_next = ISSUE;
            ISSUE:   if (instr_ready) state_next = halt ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            instr    <= 32'd0;
            instr_pc <= RESET_PC;
            epc      <= 32'd0;
            adel     <= 1'b0;
            retired  <= 32'd0;
        end else begin
            adel <= accept && trap_adel;
            if (fetch_done) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (accept) begin
                pc      <= pc_next;
                retired <= retired + 32'd1;
                if (trap) begin
                    epc <= instr_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: transaction-level PC model with random
// memory/decode stalls and redirect inputs.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exception;
    logic        halt;
    logic [31:0] epc;
    logic        adel;
    logic        halted;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_ret;

    pc_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .br_taken(br_taken), .br_offset(br_offset), .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_target(jr_target), .exception(exception), .halt(halt),
        .epc(epc), .adel(adel), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_offset   = 16'd0;
        jump        = 1'b0;
        jump_index  = 26'd0;
        jr          = 1'b0;
        jr_target   = 32'd0;
        exception   = 1'b0;
        halt        = 1'b0;
    endtask

    // One full fetch/issue/accept transaction checked against the PC model.
    task automatic run_instr(input int ackd, input int rdyd,
                             input logic br, input logic [15:0] off,
                             input logic jmp, input logic [25:0] idx,
                             input logic jrv, input logic [31:0] tgt,
                             input logic exc, input logic hlt);
        logic [31:0] word;
        logic [31:0] seq;
        logic [31:0] npc;
        logic        trap;
        logic        exp_adel;
        int          waited;
        int          o;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
        end
        checks++;
        if (imem_addr !== m_pc) begin
            errors++;
            $display("[TB] FAIL fetch_addr: got %h required %h", imem_addr, m_pc);
        end
        for (int d = 0; d < ackd; d++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom();
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fetch_hold: req=%b addr=%h valid=%b required 1/%h/0",
                         imem_req, imem_addr, instr_valid, m_pc);
            end
        end
        word       = $urandom();
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        checks++;
        if (instr_valid !== 1'b1 || instr !== word || instr_pc !== m_pc || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL issue_capture: valid=%b instr=%h pc=%h req=%b required 1/%h/%h/0",
                     instr_valid, instr, instr_pc, imem_req, word, m_pc);
        end
        checks++;
        if (adel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL adel_width: got %b required 0", adel);
        end
        for (int d = 0; d < rdyd; d++) begin
            // Inputs that must be ignored while decode is stalled.
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(0, 1));
            br_taken    = 1'($urandom_range(0, 1));
            br_offset   = 16'($urandom());
            jump        = 1'($urandom_range(0, 1));
            jump_index  = 26'($urandom());
            jr          = 1'($urandom_range(0, 1));
            jr_target   = $urandom();
            exception   = 1'($urandom_range(0, 1));
            halt        = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== word || instr_pc !== m_pc ||
                retired !== m_ret || imem_addr !== m_pc || imem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL issue_hold: valid=%b instr=%h pc=%h ret=%h addr=%h req=%b required 1/%h/%h/%h/%h/0",
                         instr_valid, instr, instr_pc, retired, imem_addr, imem_req, word, m_pc, m_ret, m_pc);
            end
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        br_taken    = br;
        br_offset   = off;
        jump        = jmp;
        jump_index  = idx;
        jr          = jrv;
        jr_target   = tgt;
        exception   = exc;
        halt        = hlt;

        seq      = m_pc + 32'd4;
        trap     = exc || (jrv && tgt[1:0] != 2'b00);
        exp_adel = !exc && jrv && (tgt[1:0] != 2'b00);
        o        = int'($signed(off));
        if (trap)      npc = EXC_VECTOR;
        else if (jrv)  npc = tgt;
        else if (jmp)  npc = (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
        else if (br)   npc = seq + 32'(o * 4);
        else           npc = seq;

        step();
        clear_inputs();
        m_ret = m_ret + 32'd1;
        if (trap) m_epc = m_pc;
        m_pc = npc;

        checks++;
        if (retired !== m_ret) begin
            errors++;
            $display("[TB] FAIL retired: got %h required %h", retired, m_ret);
        end
        checks++;
        if (epc !== m_epc) begin
            errors++;
            $display("[TB] FAIL epc: got %h required %h", epc, m_epc);
        end
        checks++;
        if (adel !== exp_adel) begin
            errors++;
            $display("[TB] FAIL adel_pulse: got %b required %b", adel, exp_adel);
        end
        checks++;
        if (imem_addr !== m_pc) begin
            errors++;
            $display("[TB] FAIL next_pc: got %h required %h", imem_addr, m_pc);
        end
        checks++;
        if (halted !== hlt || imem_req !== !hlt || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_accept_state: halted=%b req=%b valid=%b required %b/%b/0",
                     halted, imem_req, instr_valid, hlt, !hlt);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 ||
            instr !== 32'd0 || instr_pc !== RESET_PC || epc !== 32'd0 ||
            adel !== 1'b0 || halted !== 1'b0 || retired !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: req=%b addr=%h valid=%b instr=%h ipc=%h epc=%h adel=%b halted=%b ret=%h required 0/%h/0/0/%h/0/0/0/0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, epc, adel, halted, retired,
                     RESET_PC, RESET_PC);
        end
        reset = 1'b1;
        m_pc  = RESET_PC;
        m_epc = 32'd0;
        m_ret = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_cycle: imem_req=%b required 0", imem_req);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL first_fetch: req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            run_instr(0, 0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        checks++;
        if (cyc - c0 !== 8) begin
            errors++;
            $display("[TB] FAIL throughput: %0d cycles for 4 instructions required 8", cyc - c0);
        end
    endtask

    task automatic test_branch_jump();
        run_instr(0, 0, 1'b1, 16'hFFFC, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b1, 16'h0010, 1'b1, 26'h0000C10, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_instr(3, 2, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h0000_3020, 1'b0, 1'b0);
    endtask

    task automatic test_adel();
        run_instr(1, 1, 1'b1, 16'h0004, 1'b1, 26'h1, 1'b1, 32'h0000_3202, 1'b0, 1'b0);
        run_instr(0, 1, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'h0000_3203, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        run_instr(0, 0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run_instr(0, 0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b1, 16'h8000, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 40; i++) begin
            tgt = $urandom();
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0), 16'($urandom()),
                      ($urandom_range(0, 4) == 0), 26'($urandom()),
                      ($urandom_range(0, 5) == 0), tgt,
                      ($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    task automatic test_halt();
        run_instr(1, 1, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== m_pc) begin
                errors++;
                $display("[TB] FAIL halt_hold: halted=%b req=%b valid=%b addr=%h required 1/0/0/%h",
                         halted, imem_req, instr_valid, imem_addr, m_pc);
            end
        end
        do_reset();
        run_instr(0, 0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        run_instr(0, 0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: req=%b valid=%b required 0/0", imem_req, instr_valid);
        end
        do_reset();
        run_instr(2, 0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        m_pc  = RESET_PC;
        m_epc = 32'd0;
        m_ret = 32'd0;
        step();
        test_reset();
        test_back_to_back();
        test_branch_jump();
        test_stall();
        test_adel();
        test_wrap();
        test_random();
        test_halt();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch sequencer and program-counter owner for the CPU front end. It holds the architectural PC, runs a request/acknowledge fetch handshake with instruction memory, and presents each fetched instruction to decode with a valid/ready handshake. On every accepted instruction it computes the next PC from the redirect inputs: exception, register jump, absolute jump, taken branch or sequential.

## Interface
- RESET_PC, 32'h0000_3000, PC of the first fetch after reset
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception or misaligned jr target
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to current PC
- imem_ack  in  1  fetch complete, imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  captured instruction
- instr_pc  out  32  PC of instr
- instr_ready  in  1  decode accepts the instruction
- br_taken  in  1  conditional branch taken
- br_offset  in  16  branch word offset, signed
- jump  in  1  absolute jump (j/jal)
- jump_index  in  26  jump target index
- jr  in  1  register jump
- jr_target  in  32  register jump target
- exception  in  1  exception raised by the issued instruction
- halt  in  1  stop after this instruction
- epc  out  32  PC of the last excepting instruction
- adel  out  1  one-cycle pulse: misaligned jr target trapped
- halted  out  1  sequencer stopped
- retired  out  32  count of accepted instructions, wraps

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- Reset (reset=0): state IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=RESET_PC; epc=0; adel=0; halted=0; retired=0.
- IDLE: unconditionally go to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc held stable until ack. On imem_ack: capture instr=imem_rdata, instr_pc=pc, go ISSUE. imem_ack outside FETCH is ignored.
- ISSUE: instr_valid=1; instr and instr_pc held stable until instr_ready. Redirect, exception and halt inputs are sampled only on the accept cycle (instr_valid && instr_ready). Accept increments retired and selects next pc by strict priority:
  - exception: pc=EXC_VECTOR, epc=instr_pc.
  - jr with jr_target[1:0]!=0: pc=EXC_VECTOR, epc=instr_pc, adel pulses.
  - jr: pc=jr_target.
  - jump: pc={seq[31:28], jump_index, 2'b00}.
  - br_taken: pc=seq + {{14{br_offset[15]}}, br_offset, 2'b00}.
  - else: pc=seq.
  - seq = instr_pc+4. All adds are 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- After accept: halt=1 goes to HALT; otherwise go to FETCH.
- HALT: halted=1, imem_req=0, instr_valid=0. Pc is still updated per the priority above and readable on imem_addr. HALT is left only by reset.
- Simultaneous halt and exception: epc and pc update, then HALT.
- retired wraps 32'hFFFF_FFFF to 0.

## Timing
- First imem_req rises 1 cycle after reset deasserts (IDLE cycle).
- Zero-wait memory (ack same cycle as req): FETCH 1 cycle, ISSUE at least 1 cycle. Throughput is 1 instruction per 2 cycles.
- instr_valid rises the cycle after the ack cycle. The new imem_addr appears the cycle after accept.
- adel is high for exactly the cycle after accept.
- Reset asserted mid-fetch or mid-issue drops imem_req and instr_valid combinationally via the async clear. There is no partial commit.

## Test plan
- Reset release with zero-wait memory, instr_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008 every 2 cycles; retired increments on each accept.
- ack delayed 3 cycles, instr_ready delayed 2 cycles -> imem_addr and instr stable throughout; only one retired increment per instruction.
- At instr_pc=0x3010: br_taken, br_offset=16'hFFFC -> next fetch 0x3004. jump, jump_index=0x0000C10 -> next fetch 0x3040, jump beating br_taken.
- jr_target=0x3202 at instr_pc=0x3020 -> adel pulse, epc=0x3020, next fetch 0x4180. exception+jr asserted together -> EXC_VECTOR, no adel.
- halt on accept -> halted=1, imem_req stays 0 for 10 cycles. Reset pulse -> refetch from 0x3000.
- reset=0 asserted mid-FETCH -> imem_req=0 in the same cycle; after release, fetch restarts at RESET_PC with retired=0.
